// File: rtl/gcd_sched_pkg.sv
// gcd_sched_pkg
// Shared types and sizing helpers for the GCD job scheduler.
//   sched_state_t : scheduler FSM states
//   cnt_width()   : watchdog counter width for a given timeout, $clog2(TIMEOUT+1)
//   idx_width()   : requester index width for a given requester count, $clog2(N_REQ)
package gcd_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        BYPASS,
        RESP
    } sched_state_t;

    localparam int DEFAULT_N_REQ   = 4;
    localparam int DEFAULT_WIDTH   = 16;
    localparam int DEFAULT_TIMEOUT = 1023;

    // Watchdog counter must be able to hold the value TIMEOUT itself.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

    // Owner/pointer index width; never allowed to collapse to zero bits.
    function automatic int idx_width(input int n_req);
        return (n_req < 2) ? 1 : $clog2(n_req);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin picker.
//   req    : request vector, one bit per requester
//   ptr    : highest-priority requester index
//   winner : first set bit at or above ptr, wrapping to bit 0
//   any    : at least one request is set
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    winner,
    output logic             any
);

    // Two descending scans: the first leaves the lowest set bit overall
    // (the wrap-around answer), the second overrides it with the lowest
    // set bit at or above ptr whenever one exists.
    always_comb begin
        winner = '0;
        any    = |req;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner = IW'(i);
            end
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i] && (IW'(i) >= ptr)) begin
                winner = IW'(i);
            end
        end
    end

endmodule

// File: rtl/gcd_job_scheduler.sv
// gcd_job_scheduler
// Shares one subtractive GCD engine between N_REQ requesters with
// round-robin arbitration, a zero-operand bypass and a watchdog.
//   clk, rst             : clock, asynchronous active-high reset
//   req, a_in, b_in      : per-requester job request and packed operands
//   grant                : one-hot pulse, job accepted and operands captured
//   rsp_valid, rsp_gcd,
//   rsp_err              : one-hot result pulse, result value, timeout flag
//   busy                 : high whenever the scheduler is not idle
//   eng_start, eng_a,
//   eng_b                : start pulse and held operands to the engine
//   eng_done, eng_gcd    : engine completion and result
module gcd_job_scheduler
    import gcd_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_in,
    input  logic [N_REQ*WIDTH-1:0] b_in,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]       rsp_gcd,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   eng_start,
    output logic [WIDTH-1:0]       eng_a,
    output logic [WIDTH-1:0]       eng_b,
    input  logic                   eng_done,
    input  logic [WIDTH-1:0]       eng_gcd
);

    localparam int CW = cnt_width(TIMEOUT);
    localparam int IW = idx_width(N_REQ);
    localparam logic [CW-1:0] CNT_LAST   = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] OWNER_LAST = IW'(N_REQ - 1);

    sched_state_t state, next_state;

    logic [IW-1:0]    ptr, owner, winner;
    logic             any_req;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic             operand_zero, timeout_hit;
    logic [N_REQ-1:0] onehot_winner, onehot_owner;

    logic [N_REQ-1:0] grant_d, rsp_valid_d;
    logic [WIDTH-1:0] rsp_gcd_d, eng_a_d, eng_b_d;
    logic             rsp_err_d, eng_start_d, busy_d;
    logic [IW-1:0]    ptr_d, owner_d;
    logic [CW-1:0]    cnt_d;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (winner),
        .any    (any_req)
    );

    // Select the winning requester's operands and build one-hot forms of
    // the winner (for grant) and the latched owner (for the response).
    always_comb begin
        sel_a         = '0;
        sel_b         = '0;
        onehot_winner = '0;
        onehot_owner  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == IW'(i)) begin
                sel_a            = a_in[i*WIDTH +: WIDTH];
                sel_b            = b_in[i*WIDTH +: WIDTH];
                onehot_winner[i] = 1'b1;
            end
            if (owner == IW'(i)) begin
                onehot_owner[i] = 1'b1;
            end
        end
    end

    // The subtractive engine never terminates with a zero operand, so those
    // jobs are answered locally. The watchdog fires on the cycle the count
    // would reach TIMEOUT.
    assign operand_zero = (sel_a == '0) || (sel_b == '0);
    assign timeout_hit  = (cnt == CNT_LAST);

    // State register. Reset drops any job in flight without a response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. In WAIT a completing engine and an expiring watchdog
    // both lead to RESP; which result is reported is decided in the output
    // logic, where eng_done takes priority.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = operand_zero ? BYPASS : ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (eng_done || timeout_hit) next_state = RESP;
            BYPASS:  next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next values for every registered output and datapath register. Pulse
    // outputs default to zero so each lasts exactly one cycle; operand and
    // result registers hold unless a state explicitly reloads them. The
    // pointer moves only after a response, giving the just-served requester
    // the lowest priority in the next arbitration.
    always_comb begin
        grant_d     = '0;
        rsp_valid_d = '0;
        eng_start_d = 1'b0;
        rsp_err_d   = 1'b0;
        busy_d      = (next_state != IDLE);
        rsp_gcd_d   = rsp_gcd;
        eng_a_d     = eng_a;
        eng_b_d     = eng_b;
        owner_d     = owner;
        ptr_d       = ptr;
        cnt_d       = cnt;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_d     = onehot_winner;
                    eng_a_d     = sel_a;
                    eng_b_d     = sel_b;
                    owner_d     = winner;
                    eng_start_d = !operand_zero;
                end
            end
            ISSUE: begin
                cnt_d = '0;
            end
            WAIT: begin
                cnt_d = cnt + 1'b1;
                if (eng_done) begin
                    rsp_valid_d = onehot_owner;
                    rsp_gcd_d   = eng_gcd;
                end else if (timeout_hit) begin
                    rsp_valid_d = onehot_owner;
                    rsp_gcd_d   = '0;
                    rsp_err_d   = 1'b1;
                end
            end
            BYPASS: begin
                rsp_valid_d = onehot_owner;
                rsp_gcd_d   = eng_a | eng_b;
            end
            RESP: begin
                ptr_d = (owner == OWNER_LAST) ? '0 : owner + 1'b1;
            end
            default: ;
        endcase
    end

    // Output and datapath registers; every output of the block comes from here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant     <= '0;
            rsp_valid <= '0;
            rsp_gcd   <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            eng_start <= 1'b0;
            eng_a     <= '0;
            eng_b     <= '0;
            owner     <= '0;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            grant     <= grant_d;
            rsp_valid <= rsp_valid_d;
            rsp_gcd   <= rsp_gcd_d;
            rsp_err   <= rsp_err_d;
            busy      <= busy_d;
            eng_start <= eng_start_d;
            eng_a     <= eng_a_d;
            eng_b     <= eng_b_d;
            owner     <= owner_d;
            ptr       <= ptr_d;
            cnt       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_gcd_job_scheduler.sv
// tb_gcd_job_scheduler
// Directed self-checking bench for gcd_job_scheduler (N_REQ=4, WIDTH=16,
// TIMEOUT=20). The engine side is driven by hand from the stimulus code.
module tb_gcd_job_scheduler;

    localparam int N_REQ   = 4;
    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 20;

    logic                   clk;
    logic                   rst;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] a_in;
    logic [N_REQ*WIDTH-1:0] b_in;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]       rsp_gcd;
    logic                   rsp_err;
    logic                   busy;
    logic                   eng_start;
    logic [WIDTH-1:0]       eng_a;
    logic [WIDTH-1:0]       eng_b;
    logic                   eng_done;
    logic [WIDTH-1:0]       eng_gcd;

    int testsRun;
    int testsFailed;

    gcd_job_scheduler #(
        .N_REQ   (N_REQ),
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .grant     (grant),
        .rsp_valid (rsp_valid),
        .rsp_gcd   (rsp_gcd),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .eng_start (eng_start),
        .eng_a     (eng_a),
        .eng_b     (eng_b),
        .eng_done  (eng_done),
        .eng_gcd   (eng_gcd)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a wait is ever left unbounded by mistake.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1);
    end

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", tag, actual, expected);
        end
    endtask

    // Raise one requester's request with its operands.
    task automatic applyStimulus(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req[idx]                 = 1'b1;
        a_in[idx*WIDTH +: WIDTH] = a;
        b_in[idx*WIDTH +: WIDTH] = b;
    endtask

    // One engine-path job whose request is already raised: checks grant and
    // start, lets the engine finish after 'latency' WAIT cycles, then checks
    // the response (bounded wait).
    task automatic engineJob(input int idx, input logic [WIDTH-1:0] expA, input logic [WIDTH-1:0] expB,
                             input int latency, input logic [WIDTH-1:0] result, input bit dropReq);
        int waited;
        tick();
        checkOutput("grant", 32'(grant), 32'(1) << idx);
        checkOutput("eng_start", 32'(eng_start), 32'd1);
        checkOutput("eng_a", 32'(eng_a), 32'(expA));
        checkOutput("eng_b", 32'(eng_b), 32'(expB));
        if (dropReq) req[idx] = 1'b0;
        tick();
        checkOutput("start_once", 32'(eng_start), 32'd0);
        repeat (latency - 1) tick();
        eng_gcd  = result;
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        waited = 0;
        while (rsp_valid == '0 && waited < 4) begin
            tick();
            waited++;
        end
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(1) << idx);
        checkOutput("rsp_gcd", 32'(rsp_gcd), 32'(result));
        checkOutput("rsp_err", 32'(rsp_err), 32'd0);
        tick();
        checkOutput("rsp_pulse", 32'(rsp_valid), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
    endtask

    // Zero-operand job: grant at cycle 1, response at cycle 2, no engine start.
    task automatic bypassJob(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [WIDTH-1:0] expGcd);
        applyStimulus(idx, a, b);
        tick();
        checkOutput("byp_grant", 32'(grant), 32'(1) << idx);
        checkOutput("byp_nostart1", 32'(eng_start), 32'd0);
        checkOutput("byp_busy", 32'(busy), 32'd1);
        req[idx] = 1'b0;
        tick();
        checkOutput("byp_nostart2", 32'(eng_start), 32'd0);
        checkOutput("byp_valid", 32'(rsp_valid), 32'(1) << idx);
        checkOutput("byp_gcd", 32'(rsp_gcd), 32'(expGcd));
        checkOutput("byp_err", 32'(rsp_err), 32'd0);
        tick();
        checkOutput("byp_pulse", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        req         = '0;
        a_in        = '0;
        b_in        = '0;
        eng_done    = 1'b0;
        eng_gcd     = '0;

        // Reset values
        repeat (2) tick();
        checkOutput("rst_grant", 32'(grant), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("rst_eng_start", 32'(eng_start), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_rsp_gcd", 32'(rsp_gcd), 32'd0);
        checkOutput("rst_eng_a", 32'(eng_a), 32'd0);
        checkOutput("rst_eng_b", 32'(eng_b), 32'd0);
        rst = 1'b0;
        tick();

        // Round robin: all requesters continuously asking, A=B=7.
        // Expected grant order 0,1,2,3,0.
        for (int k = 0; k < N_REQ; k++) applyStimulus(k, 16'd7, 16'd7);
        for (int k = 0; k < 5; k++) begin
            engineJob(k % N_REQ, 16'd7, 16'd7, 3, 16'd7, 1'b0);
        end
        req = '0;

        // Single job: requester 2, 48/18, engine answers 6 after 10 cycles.
        applyStimulus(2, 16'd48, 16'd18);
        engineJob(2, 16'd48, 16'd18, 10, 16'd6, 1'b1);

        // Zero operands answered directly.
        bypassJob(1, 16'd0, 16'd35, 16'd35);
        bypassJob(3, 16'd12, 16'd0, 16'd12);
        bypassJob(0, 16'd0, 16'd0, 16'd0);

        // Timeout: engine never finishes; response 20 cycles after WAIT entry.
        applyStimulus(0, 16'd40, 16'd30);
        tick();
        checkOutput("to_grant", 32'(grant), 32'd1);
        req[0] = 1'b0;
        tick();
        repeat (TIMEOUT - 1) tick();
        checkOutput("to_early", 32'(rsp_valid), 32'd0);
        tick();
        checkOutput("to_valid", 32'(rsp_valid), 32'd1);
        checkOutput("to_gcd", 32'(rsp_gcd), 32'd0);
        checkOutput("to_err", 32'(rsp_err), 32'd1);
        tick();
        checkOutput("to_pulse", 32'(rsp_valid), 32'd0);

        // Next job after a timeout completes normally.
        applyStimulus(1, 16'd100, 16'd75);
        engineJob(1, 16'd100, 16'd75, 5, 16'd25, 1'b1);

        // eng_done on the very cycle the watchdog would fire: result wins.
        applyStimulus(3, 16'd27, 16'd18);
        tick();
        checkOutput("edge_grant", 32'(grant), 32'd8);
        req[3] = 1'b0;
        tick();
        repeat (TIMEOUT - 1) tick();
        eng_gcd  = 16'd9;
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        checkOutput("edge_valid", 32'(rsp_valid), 32'd8);
        checkOutput("edge_gcd", 32'(rsp_gcd), 32'd9);
        checkOutput("edge_err", 32'(rsp_err), 32'd0);
        tick();

        // Spurious eng_done while idle is ignored.
        eng_gcd  = 16'd99;
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        checkOutput("spur_busy", 32'(busy), 32'd0);
        checkOutput("spur_valid", 32'(rsp_valid), 32'd0);
        checkOutput("spur_grant", 32'(grant), 32'd0);
        tick();
        checkOutput("spur_valid2", 32'(rsp_valid), 32'd0);
        checkOutput("spur_gcd", 32'(rsp_gcd), 32'd9);

        // Move the pointer away from 0 (serves 2, pointer becomes 3).
        bypassJob(2, 16'd0, 16'd5, 16'd5);

        // Reset during WAIT, with requesters 1 and 3 pending.
        applyStimulus(2, 16'd60, 16'd45);
        tick();
        checkOutput("rw_grant", 32'(grant), 32'd4);
        req = '0;
        applyStimulus(1, 16'd21, 16'd14);
        applyStimulus(3, 16'd8, 16'd12);
        tick();
        tick();
        checkOutput("rw_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rw_busy", 32'(busy), 32'd0);
        checkOutput("rw_grant0", 32'(grant), 32'd0);
        checkOutput("rw_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rw_rsp_gcd", 32'(rsp_gcd), 32'd0);
        checkOutput("rw_eng_start", 32'(eng_start), 32'd0);
        checkOutput("rw_eng_a", 32'(eng_a), 32'd0);
        checkOutput("rw_eng_b", 32'(eng_b), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("rw_restart_grant", 32'(grant), 32'd2);
        checkOutput("rw_restart_eng_a", 32'(eng_a), 32'd21);
        req = '0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
